// File: rtl/fdivsqrt_sched_pkg.sv
// fdivsqrt_sched_pkg: shared types and defaults for the div/sqrt scheduling controller
package fdivsqrt_sched_pkg;
  localparam int DURLEN_DEF = 6;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/fdivsqrt_rr_arb2.sv
// fdivsqrt_rr_arb2: two-way FP/integer arbiter; a tie goes to whichever side did not win last (FAIR) or to FP
module fdivsqrt_rr_arb2 #(
  parameter bit FAIR = 1'b1
) (
  input  logic req_f_i,
  input  logic req_i_i,
  input  logic last_int_i,
  input  logic en_i,
  output logic gnt_f_o,
  output logic gnt_i_o
);
  logic int_wins_tie;
  assign int_wins_tie = FAIR & ~last_int_i;
  assign gnt_f_o = en_i & req_f_i & (~req_i_i | ~int_wins_tie);
  assign gnt_i_o = en_i & req_i_i & (~req_f_i | int_wins_tie);
endmodule

// File: rtl/fdivsqrt_sched_ctrl.sv
// fdivsqrt_sched_ctrl: grants the shared div/sqrt datapath, counts iterations down and signals per-requester done
module fdivsqrt_sched_ctrl
  import fdivsqrt_sched_pkg::*;
#(
  parameter int DURLEN = DURLEN_DEF,
  parameter bit FAIR   = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              FDivReqE,
  input  logic              IDivReqE,
  input  logic [DURLEN-1:0] CyclesE,
  input  logic              SpecialCaseE,
  input  logic              FlushE,
  input  logic              StallM,
  output logic              FGrantE,
  output logic              IGrantE,
  output logic              IFDivStartE,
  output logic              IterEnE,
  output logic              DivBusyE,
  output logic              FDivDoneM,
  output logic              IDivDoneM
);
  state_t            state_q;
  logic [DURLEN-1:0] cnt_q;
  logic              op_int_q;
  logic              last_int_q;
  logic              idle;
  assign idle = state_q == IDLE;
  // reset_n gates the grants so every output reads 0 while reset is held
  fdivsqrt_rr_arb2 #(.FAIR(FAIR)) u_arb (
    .req_f_i   (FDivReqE),
    .req_i_i   (IDivReqE),
    .last_int_i(last_int_q),
    .en_i      (idle & ~FlushE & reset_n),
    .gnt_f_o   (FGrantE),
    .gnt_i_o   (IGrantE)
  );
  assign IFDivStartE = FGrantE | IGrantE;
  assign IterEnE     = state_q == BUSY;
  assign DivBusyE    = ~idle;
  assign FDivDoneM   = (state_q == DONE) & ~op_int_q;
  assign IDivDoneM   = (state_q == DONE) & op_int_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_int_q   <= 1'b0;
      last_int_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (IFDivStartE) begin
          op_int_q   <= IGrantE;
          last_int_q <= IGrantE;
          if (SpecialCaseE || CyclesE == '0) state_q <= DONE;
          else begin
            cnt_q   <= CyclesE;
            state_q <= BUSY;
          end
        end
        BUSY: if (FlushE || cnt_q == DURLEN'(1)) begin
          cnt_q   <= '0;
          state_q <= FlushE ? IDLE : DONE;
        end else if (cnt_q != '0) cnt_q <= cnt_q - DURLEN'(1);
        DONE: if (FlushE || !StallM) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
